datetime_to_binary: RTL
=======================

// Module: datetime_to_binary
// PURPOSE
//   Inverse of the binary-time-to-calendar converter: takes a calendar date/time
//   (YYYY-MM-DD hh:mm:ss) and produces t, the 28-bit count of seconds since
//   BASE_YEAR-01-01 00:00:00. It is used to load or set the binary time counter
//   from user-entered values.
//   Multi-cycle iterative FSM: one add per elapsed year and per elapsed month,
//   then three multiply-accumulate steps. Inputs are range-checked.
// PARAMETERS
//   BASE_YEAR  2020  year that maps to t=0
//   NUM_YEARS  6     number of supported years: BASE_YEAR .. BASE_YEAR+NUM_YEARS-1
// PORTS
//   clk     input   1   clock, rising edge
//   rst_n   input   1   asynchronous reset, active low
//   start   input   1   request; sampled only in IDLE
//   YYYY    input   11  year
//   MM      input   4   month, 1..12
//   DD      input   5   day, 1..31
//   hh      input   5   hour, 0..23
//   mm      input   6   minute, 0..59
//   ss      input   6   second, 0..59
//   busy    output  1   high from the cycle after start is accepted until done
//   done    output  1   one-cycle pulse; t and err are valid in this cycle
//   err     output  1   invalid input on the last conversion
//   t       output  28  seconds since BASE_YEAR-01-01 00:00:00
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - state=IDLE; busy=0, done=0, err=0, t=0; internal registers cleared.
//   - A reset mid-conversion aborts it. No done is issued.
// - Accept: in IDLE, start=1 at a clock edge latches all six inputs.
//   - The FSM moves to CHECK. Input changes after acceptance have no effect.
//   - start while busy=1 is ignored and is not queued.
// - States and transitions:
//   - IDLE:  on start go to CHECK.
//   - CHECK: validate the inputs.
//     - Invalid: err_r=1, t_r=0, go to DONE.
//     - Valid: acc=DD-1, ycnt=BASE_YEAR, mcnt=1, go to YEAR.
//   - YEAR:  if ycnt<YYYY then acc += (ycnt[1:0]==0 ? 366 : 365) and ycnt++.
//     Otherwise go to MONTH. This takes YYYY-BASE_YEAR+1 cycles.
//   - MONTH: if mcnt<MM then acc += days_in_month(mcnt, leap(YYYY)) and mcnt++.
//     Otherwise go to HOUR. This takes MM cycles.
//   - HOUR:  acc = acc*24 + hh.
//   - MIN:   acc = acc*60 + mm.
//   - SEC:   acc = acc*60 + ss.
//   - DONE:  t=acc, err=0 (or the error values), done=1 for one cycle, go to IDLE.
// - Validation fails if any of the following holds:
//   - YYYY<BASE_YEAR, or YYYY>BASE_YEAR+NUM_YEARS-1
//   - MM==0 or MM>12
//   - DD==0, or DD>days_in_month(MM, leap(YYYY)); February is 29 in a leap year, else 28
//   - hh>23, mm>59, or ss>59
// - Leap rule: year[1:0]==0. This is exact for 2000..2099.
// - Widths:
//   - acc is 28 bits.
//   - The maximum result, 2025-12-31 23:59:59, is 189,388,799, below 2^28.
//   - No intermediate value overflows.
//   - The *24 and *60 steps are shift-add on constants; no generic multiplier.
// - Latency, counting the start-accept edge as edge 0:
//   - Valid input: done is high after edge N = (YYYY-BASE_YEAR) + MM + 5.
//   - Invalid input: N = 1.
//   - busy drops in the same cycle done rises.
// - Outputs:
//   - t and err hold their values after done until the next DONE.
//   - busy=0 in IDLE; otherwise busy=1, except in DONE.
// - Back-to-back: start may be high in the cycle after done, since the FSM is
//   then in IDLE, and is accepted.
// TESTING
// - 2020-01-01 00:00:00 -> t=0, err=0, done at N=6.
// - 2020-03-01 00:00:00 -> t=5,184,000 (60 days), done at N=8; checks the leap-Feb add.
// - 2024-02-29 12:34:56 -> t=131,373,296, err=0, N=11.
// - 2025-12-31 23:59:59 -> t=189,388,799, N=22.
// - Invalid inputs -> err=1, t=0, done at N=1:
//   - 2021-02-29
//   - MM=13
//   - hh=24
//   - YYYY=2026
//   - DD=0
// - start pulsed while busy -> ignored, first result unchanged.
// - rst_n low mid-YEAR -> busy=0, t=0, no done.
// - A new start after reset converts correctly.
// - Round-trip: feed t back through the binary-to-calendar converter for random
//   valid dates; the fields must match.

Source files
------------

// File: rtl/datetime_to_binary_if.sv
// Request/response bundle between a controller and the calendar-to-seconds converter.
interface datetime_to_binary_if;
    logic        start;
    logic [10:0] YYYY;
    logic [3:0]  MM;
    logic [4:0]  DD;
    logic [4:0]  hh;
    logic [5:0]  mm;
    logic [5:0]  ss;
    logic        busy;
    logic        done;
    logic        err;
    logic [27:0] t;

    modport master (
        output start, YYYY, MM, DD, hh, mm, ss,
        input  busy, done, err, t
    );

    modport slave (
        input  start, YYYY, MM, DD, hh, mm, ss,
        output busy, done, err, t
    );
endinterface

// File: rtl/datetime_to_binary.sv
// Converts a calendar date/time into seconds since BASE_YEAR-01-01 00:00:00.
// Iterative: one add per elapsed year and month, then shift-add scaling
// through hours, minutes and seconds.
//
// state   | meaning
// --------+---------------------------------------------------
// S_IDLE  | waiting for start; inputs latched on accept
// S_CHECK | range-check latched fields, seed accumulator
// S_YEAR  | add 365/366 per elapsed year
// S_MONTH | add days of each elapsed month of the target year
// S_HOUR  | acc = acc*24 + hh
// S_MIN   | acc = acc*60 + mm
// S_SEC   | acc = acc*60 + ss, publish result, raise done
// S_DONE  | done pulse cycle, return to idle
module datetime_to_binary #(
    parameter int BASE_YEAR = 2020,
    parameter int NUM_YEARS = 6
) (
    input  logic clk,
    input  logic rst_n,
    datetime_to_binary_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_YEAR, S_MONTH, S_HOUR, S_MIN, S_SEC, S_DONE
    } state_t;

    localparam logic [10:0] YMIN = 11'(BASE_YEAR);
    localparam logic [10:0] YMAX = 11'(BASE_YEAR + NUM_YEARS - 1);

    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic leap);
        case (m)
            4'd2:                      return leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
            default:                   return 5'd31;
        endcase
    endfunction

    state_t      state;
    logic [10:0] y_r;
    logic [3:0]  m_r;
    logic [4:0]  d_r;
    logic [4:0]  h_r;
    logic [5:0]  mi_r;
    logic [5:0]  s_r;
    logic [27:0] acc;
    logic [10:0] ycnt;
    logic [3:0]  mcnt;
    logic [27:0] t_r;
    logic        err_r;
    logic        done_r;
    logic        busy_r;

    logic        leap_y;
    logic        fields_ok;
    logic [27:0] acc_x24;
    logic [27:0] acc_x60;

    // Input validation and constant-multiply helpers on the latched fields.
    always_comb begin
        leap_y    = (y_r[1:0] == 2'b00);
        fields_ok = 1'b1;
        if (y_r < YMIN || y_r > YMAX)                        fields_ok = 1'b0;
        if (m_r == 4'd0 || m_r > 4'd12)                      fields_ok = 1'b0;
        else if (d_r == 5'd0 || d_r > days_in_month(m_r, leap_y)) fields_ok = 1'b0;
        if (d_r == 5'd0)                                     fields_ok = 1'b0;
        if (h_r > 5'd23 || mi_r > 6'd59 || s_r > 6'd59)      fields_ok = 1'b0;
        acc_x24 = (acc << 4) + (acc << 3);
        acc_x60 = (acc << 6) - (acc << 2);
    end

    // Conversion FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            y_r    <= '0;
            m_r    <= '0;
            d_r    <= '0;
            h_r    <= '0;
            mi_r   <= '0;
            s_r    <= '0;
            acc    <= '0;
            ycnt   <= '0;
            mcnt   <= '0;
            t_r    <= '0;
            err_r  <= 1'b0;
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        y_r    <= bus.YYYY;
                        m_r    <= bus.MM;
                        d_r    <= bus.DD;
                        h_r    <= bus.hh;
                        mi_r   <= bus.mm;
                        s_r    <= bus.ss;
                        busy_r <= 1'b1;
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!fields_ok) begin
                        err_r  <= 1'b1;
                        t_r    <= '0;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        acc   <= 28'(d_r) - 28'd1;
                        ycnt  <= YMIN;
                        mcnt  <= 4'd1;
                        state <= S_YEAR;
                    end
                end
                S_YEAR: begin
                    if (ycnt < y_r) begin
                        acc  <= acc + ((ycnt[1:0] == 2'b00) ? 28'd366 : 28'd365);
                        ycnt <= ycnt + 11'd1;
                    end else begin
                        state <= S_MONTH;
                    end
                end
                S_MONTH: begin
                    if (mcnt < m_r) begin
                        acc  <= acc + 28'(days_in_month(mcnt, leap_y));
                        mcnt <= mcnt + 4'd1;
                    end else begin
                        state <= S_HOUR;
                    end
                end
                S_HOUR: begin
                    acc   <= acc_x24 + 28'(h_r);
                    state <= S_MIN;
                end
                S_MIN: begin
                    acc   <= acc_x60 + 28'(mi_r);
                    state <= S_SEC;
                end
                S_SEC: begin
                    t_r    <= acc_x60 + 28'(s_r);
                    err_r  <= 1'b0;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    done_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.err  = err_r;
    assign bus.t    = t_r;

endmodule
